alu_seq: RTL and testbench

- Parametrised, clocked successor to the datapath ALU.
- Operand width is a parameter. Results and flags are registered.
- A start/busy/done handshake is added. Rotate runs as a multi-cycle, one-bit-per-cycle operation, so no wide barrel shifter is needed.
- Sits between the register file read ports and the writeback/branch logic of the JAY core.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_comb_core.sv | 57 +++++
 rtl/alu_seq.sv | 116 +++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_pkg;

  // 3-bit opcode, matches the alu_cmd encoding seen on the core's decode bus
  typedef enum logic [2:0] {
    OP_PASS  = 3'b000,
    OP_SHL   = 3'b001,
    OP_ZTEST = 3'b010,
    OP_XOR   = 3'b011,
    OP_ROTL  = 3'b100,
    OP_AND   = 3'b101,
    OP_SUB   = 3'b110,
    OP_ADD   = 3'b111
  } op_e;

  // Controller states: idle/accepting, or walking a rotate one bit per cycle
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath plus zero/parity/absolute-jump flag derivation.
// ROTL passes A straight through: the rotation itself is done bit-serially
// by the sequencer, which hands the already-rotated value in on A.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sc_in,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_out,
  output logic             zero,
  output logic             pari,
  output logic             absj
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the borrow
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; every op defaults to pass-through with no carry or jump
  always_comb begin
    rslt   = a;
    sc_out = 1'b0;
    absj   = 1'b0;
    unique case (op_e'(op))
      OP_PASS:  rslt = a;
      OP_SHL: begin
        rslt   = {a[WIDTH-2:0], sc_in};
        sc_out = a[WIDTH-1];
      end
      OP_ZTEST: absj = (a == '0);
      OP_XOR:   rslt = a ^ b;
      OP_ROTL:  rslt = a;
      OP_AND:   rslt = a & b;
      OP_SUB: begin
        rslt   = diff[WIDTH-1:0];
        sc_out = ~diff[WIDTH];
      end
      OP_ADD: begin
        rslt   = sum[WIDTH-1:0];
        sc_out = sum[WIDTH];
      end
      default: rslt = a;
    endcase
  end

  assign zero = (rslt == '0);
  assign pari = ^rslt;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/done handshake. Single-cycle ops complete on
// the accept edge; ROTL by k>0 rotates a work register one bit per cycle and
// writes back on the k-th edge after accept.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             sc_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_o,
  output logic             zero,
  output logic             pari,
  output logic             absj
);

  localparam logic [WIDTH-1:0] W_L = WIDTH'(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] work;
  logic [CNTW-1:0]  cnt;

  logic [WIDTH-1:0] k_full;
  logic [WIDTH-1:0] rot_nxt;
  logic [2:0]       core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_rslt;
  logic             core_sc;
  logic             core_zero;
  logic             core_pari;
  logic             core_absj;
  logic             rot_req;

  // Full-width B reduced mod WIDTH, so non-power-of-2 widths wrap correctly
  assign k_full  = inB % W_L;
  assign rot_req = (op_e'(alu_cmd) == OP_ROTL) && (k_full != '0);
  assign rot_nxt = {work[WIDTH-2:0], work[WIDTH-1]};

  // While rotating, the core sees the final rotated value as a ROTL pass-through
  assign core_op = (state == ST_ROT) ? 3'(OP_ROTL) : alu_cmd;
  assign core_a  = (state == ST_ROT) ? rot_nxt : inA;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op     (core_op),
    .a      (core_a),
    .b      (inB),
    .sc_in  (sc_i),
    .rslt   (core_rslt),
    .sc_out (core_sc),
    .zero   (core_zero),
    .pari   (core_pari),
    .absj   (core_absj)
  );

  // Controller, rotate work/count registers and registered results/flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      work  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rslt  <= '0;
      sc_o  <= 1'b0;
      zero  <= 1'b0;
      pari  <= 1'b0;
      absj  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (rot_req) begin
              work  <= inA;
              cnt   <= CNTW'(k_full);
              state <= ST_ROT;
              busy  <= 1'b1;
            end else begin
              rslt <= core_rslt;
              sc_o <= core_sc;
              zero <= core_zero;
              pari <= core_pari;
              absj <= core_absj;
              done <= 1'b1;
            end
          end
        end
        ST_ROT: begin
          work <= rot_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == CNTW'(1)) begin
            rslt  <= core_rslt;
            sc_o  <= core_sc;
            zero  <= core_zero;
            pari  <= core_pari;
            absj  <= core_absj;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH = 8, 16 and 5, one instance per width.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [3];
  logic [2:0]  cmd_v   [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        sci_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] r_v     [3];
  logic        sco_v   [3];
  logic        zero_v  [3];
  logic        pari_v  [3];
  logic        absj_v  [3];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int W = (i == 0) ? 8 : (i == 1) ? 16 : 5;
    logic [W-1:0] r_w;
    alu_seq #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[i]), .alu_cmd(cmd_v[i]),
      .inA(a_v[i][W-1:0]), .inB(b_v[i][W-1:0]), .sc_i(sci_v[i]),
      .busy(busy_v[i]), .done(done_v[i]), .rslt(r_w), .sc_o(sco_v[i]),
      .zero(zero_v[i]), .pari(pari_v[i]), .absj(absj_v[i])
    );
    assign r_v[i] = 16'(r_w);
  end

  function automatic int wid(input int d);
    return (d == 0) ? 8 : (d == 1) ? 16 : 5;
  endfunction

  // Reference: results straight from the opcode definitions in plain arithmetic
  function automatic void model(input int w, input int cmd, input longint a,
                                input longint b, input bit sci,
                                output longint r, output bit c, output bit aj,
                                output int k);
    longint m = (longint'(1) << w) - 1;
    longint s;
    c = 0; aj = 0; k = 0; r = a;
    case (cmd)
      0: r = a;
      1: begin r = ((a << 1) | longint'(sci)) & m; c = bit'((a >> (w - 1)) & 1); end
      2: begin r = a; aj = (a == 0); end
      3: r = a ^ b;
      4: begin k = int'(b % w); r = ((a << k) | (a >> (w - k))) & m; end
      5: r = a & b;
      6: begin r = (a - b) & m; c = (a >= b); end
      default: begin s = a + b; r = s & m; c = bit'(s >> w); end
    endcase
  endfunction

  // Present an op at a falling edge; return at the falling edge showing done
  task automatic run_op(input int d, input int cmd, input longint a, input longint b,
                        input bit sci, output int nbusy, output int ncyc, output bit got);
    longint m = (longint'(1) << wid(d)) - 1;
    cmd_v[d] = 3'(cmd); a_v[d] = 16'(a & m); b_v[d] = 16'(b & m);
    sci_v[d] = sci; start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    cmd_v[d] = 3'($urandom); a_v[d] = 16'($urandom); b_v[d] = 16'($urandom);
    sci_v[d] = 1'($urandom);
    nbusy = 0; ncyc = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (done_v[d]) got = 1;
      else begin
        if (busy_v[d]) nbusy++;
        ncyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    int nb, nc; bit got; int dones;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 0; cmd_v[d] = 0; a_v[d] = 0; b_v[d] = 0; sci_v[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({busy_v[d], done_v[d], r_v[d], sco_v[d], zero_v[d], pari_v[d], absj_v[d]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b rslt=%h sc=%b z=%b p=%b aj=%b, want all 0",
                 d, busy_v[d], done_v[d], r_v[d], sco_v[d], zero_v[d], pari_v[d], absj_v[d]);
      end
    end
    rst_n = 1'b1;
    run_op(0, 7, 'hF0, 'h20, 0, nb, nc, got);
    n_cmp++;
    if (r_v[0] !== 16'h10 || sco_v[0] !== 1'b1 || got !== 1'b1) begin
      n_bad++; $display("FAIL reset_preload: rslt=%h sc=%b got=%b, want 10/1/1", r_v[0], sco_v[0], got);
    end
    // ROTL by 5, then reset two cycles into the rotate
    cmd_v[0] = 3'd4; a_v[0] = 16'h81; b_v[0] = 16'd5; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (busy_v[0] !== 1'b1 || r_v[0] !== 16'h10) begin
      n_bad++; $display("FAIL reset_no_edge: busy=%b rslt=%h, want 1/10", busy_v[0], r_v[0]);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy_v[0], done_v[0], r_v[0], sco_v[0], zero_v[0], pari_v[0], absj_v[0]} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_rot: busy=%b done=%b rslt=%h sc=%b z=%b p=%b, want all 0",
               busy_v[0], done_v[0], r_v[0], sco_v[0], zero_v[0], pari_v[0]);
    end
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin @(negedge clk); if (done_v[0] || busy_v[0]) dones++; end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL reset_abort: %0d done/busy cycles after release, want 0", dones);
    end
  endtask

  // Directed plan vectors then random ops, each against the reference model
  task automatic test_ops(input int d);
    int w = wid(d);
    longint m = (longint'(1) << w) - 1;
    int cmds[$] = '{7, 7, 4, 4, 4, 2, 2, 6, 1, 5, 3, 0, 4};
    longint as[$] = '{'hF0, 'hFF, 'h81, 'h81, 'h81, 0, 7, 3, 1 << (w - 1), 5, 'h5A, 'h33, 'h11};
    longint bs[$] = '{'h20, 1, 3, w, w + 3, 0, 0, 5, 0, 3, 'h3C, 0, 7};
    bit     ss[$] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    repeat (40) begin
      cmds.push_back(int'($urandom_range(0, 7)));
      as.push_back(longint'($urandom) & m);
      bs.push_back(longint'($urandom) & m);
      ss.push_back(1'($urandom));
    end
    foreach (cmds[i]) begin
      longint a = as[i] & m, b = bs[i] & m, er;
      bit ec, eaj, got; int ek, nb, nc, idle;
      model(w, cmds[i], a, b, ss[i], er, ec, eaj, ek);
      run_op(d, cmds[i], a, b, ss[i], nb, nc, got);
      n_cmp++;
      if (got !== 1'b1 || nb != ek || nc != ek) begin
        n_bad++;
        $display("FAIL op_timing w%0d #%0d cmd%0d: done=%b busy_cycles=%0d lat=%0d, want 1/%0d/%0d",
                 w, i, cmds[i], got, nb, nc, ek, ek);
      end
      n_cmp++;
      if (r_v[d] !== 16'(er) || sco_v[d] !== ec || absj_v[d] !== eaj ||
          zero_v[d] !== (er == 0) || pari_v[d] !== ($countones(er) % 2 == 1)) begin
        n_bad++;
        $display("FAIL op_result w%0d #%0d cmd%0d a=%h b=%h: rslt=%h sc=%b aj=%b z=%b p=%b, want %h/%b/%b/%b/%b",
                 w, i, cmds[i], a, b, r_v[d], sco_v[d], absj_v[d], zero_v[d], pari_v[d],
                 er, ec, eaj, er == 0, $countones(er) % 2 == 1);
      end
      idle = int'($urandom_range(0, 2));
      if (idle > 0) begin
        repeat (idle) @(negedge clk);
        n_cmp++;
        if (done_v[d] !== 1'b0 || r_v[d] !== 16'(er)) begin
          n_bad++;
          $display("FAIL done_pulse w%0d #%0d: done=%b rslt=%h, want 0/%h", w, i, done_v[d], r_v[d], er);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int nb = 0, dones = 0;
    cmd_v[0] = 3'd4; a_v[0] = 16'h81; b_v[0] = 16'd3; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[0]) dones++;
      if (busy_v[0]) nb++;
      if (i == 0) begin cmd_v[0] = 3'd3; a_v[0] = 16'hFF; b_v[0] = 16'h0F; start_v[0] = 1'b1; end
      if (i == 1) start_v[0] = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (dones != 1 || nb != 3 || r_v[0] !== 16'h0C) begin
      n_bad++;
      $display("FAIL busy_ignore: dones=%0d busy_cycles=%0d rslt=%h, want 1/3/0c", dones, nb, r_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    int nb, nc; bit got;
    run_op(0, 7, 1, 2, 0, nb, nc, got);
    run_op(0, 5, 5, 3, 0, nb, nc, got);
    n_cmp++;
    if (got !== 1'b1 || nc != 0 || r_v[0] !== 16'h01) begin
      n_bad++;
      $display("FAIL back_to_back: done=%b lat=%0d rslt=%h, want 1/0/01", got, nc, r_v[0]);
    end
  endtask

  task automatic test_hold();
    int nb, nc, bad = 0; bit got;
    run_op(1, 7, 'h1234, 'h4321, 0, nb, nc, got);
    repeat (5) begin
      cmd_v[1] = 3'($urandom); a_v[1] = 16'($urandom); b_v[1] = 16'($urandom);
      @(negedge clk);
      if (r_v[1] !== 16'h5555 || done_v[1] !== 1'b0 || pari_v[1] !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL output_hold: %0d bad idle cycles, rslt=%h, want 0 / 5555", bad, r_v[1]);
    end
  endtask

  initial begin
    test_reset();
    for (int d = 0; d < 3; d++) test_ops(d);
    test_busy_ignore();
    test_back_to_back();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
